// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO with error flags, threshold, overrun and character timeout
//
// Buffers bytes completed by the UART receiver, each tagged with a framing-error
// flag, and presents the oldest entry first-word-fall-through to the register file.
//
// Ports:
//   PCLK, PRESETn   clock, asynchronous active-low reset
//   rx_data         received byte, qualified by rx_done_tick / rx_error_tick
//   rx_done_tick    one-cycle pulse: good byte received
//   rx_error_tick   one-cycle pulse: byte received with framing error
//   s_tick          baud oversample tick, drives the idle timeout counter
//   flush           synchronous clear of contents and timeout
//   pop             one-cycle pulse: discard head entry
//   ovr_clr         clear sticky overrun
//   thresh          fill threshold (0 disables thresh_hit)
//   dout, dout_err  head entry, forced to 0 when empty
//   empty, full     occupancy flags
//   level           entries held, 0..DEPTH
//   thresh_hit      level >= thresh and thresh != 0
//   overrun         sticky: a byte was dropped because the FIFO was full
//   timeout         sticky: non-empty and idle for TIMEOUT_TICKS s_ticks
module uart_rx_fifo #(
    parameter int DEPTH         = 16,
    parameter int AW            = 4,
    parameter int TIMEOUT_TICKS = 640,
    parameter int TW            = 10
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    input  logic [7:0]    rx_data,
    input  logic          rx_done_tick,
    input  logic          rx_error_tick,
    input  logic          s_tick,
    input  logic          flush,
    input  logic          pop,
    input  logic          ovr_clr,
    input  logic [AW:0]   thresh,
    output logic [7:0]    dout,
    output logic          dout_err,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level,
    output logic          thresh_hit,
    output logic          overrun,
    output logic          timeout
);

    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_TICKS);

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   lvl;
    logic [TW-1:0] idle_cnt;
    logic          ovr_q;
    logic          tmo_q;

    logic push_req;
    logic do_push;
    logic do_pop;
    logic ovr_set;

    assign push_req = rx_done_tick | rx_error_tick;
    assign empty    = (lvl == '0);
    assign full     = (lvl == FULL_LVL);

    // A pop on an empty FIFO is ignored; flush overrides both push and pop.
    assign do_pop   = pop & ~empty & ~flush;
    // When full, a push is only accepted if a pop frees the slot in the same cycle.
    assign do_push  = push_req & ~flush & (~full | do_pop);
    // Full implies non-empty, so a concurrent pop always rescues the push.
    assign ovr_set  = push_req & full & ~pop & ~flush;

    // Storage is intentionally not reset; empty gates the read path instead.
    always_ff @(posedge PCLK) begin
        if (do_push) begin
            mem[wr_ptr] <= {rx_error_tick, rx_data};
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            lvl      <= '0;
            idle_cnt <= '0;
            ovr_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                lvl    <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({do_push, do_pop})
                    2'b10:   lvl <= lvl + 1'b1;
                    2'b01:   lvl <= lvl - 1'b1;
                    default: lvl <= lvl;
                endcase
            end

            // Any receive activity or host read restarts the idle measurement.
            if (flush || push_req || do_pop || empty) begin
                idle_cnt <= '0;
            end else if (s_tick && idle_cnt != TO_MAX) begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            // Push does not clear timeout: the host must read to acknowledge it.
            if (flush || do_pop || empty) begin
                tmo_q <= 1'b0;
            end else if (idle_cnt == TO_MAX) begin
                tmo_q <= 1'b1;
            end

            if (ovr_set) begin
                ovr_q <= 1'b1;
            end else if (ovr_clr) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign dout       = empty ? 8'h00 : mem[rd_ptr][7:0];
    assign dout_err   = empty ? 1'b0  : mem[rd_ptr][8];
    assign level      = lvl;
    assign thresh_hit = (thresh != '0) && (lvl >= thresh);
    assign overrun    = ovr_q;
    assign timeout    = tmo_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int TO    = 640;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_done_tick = 1'b0;
    logic       rx_error_tick = 1'b0;
    logic       s_tick = 1'b0;
    logic       flush = 1'b0;
    logic       pop = 1'b0;
    logic       ovr_clr = 1'b0;
    logic [4:0] thresh = '0;
    logic [7:0] dout;
    logic       dout_err;
    logic       empty;
    logic       full;
    logic [4:0] level;
    logic       thresh_hit;
    logic       overrun;
    logic       timeout;

    uart_rx_fifo dut (
        .PCLK          (PCLK),
        .PRESETn       (PRESETn),
        .rx_data       (rx_data),
        .rx_done_tick  (rx_done_tick),
        .rx_error_tick (rx_error_tick),
        .s_tick        (s_tick),
        .flush         (flush),
        .pop           (pop),
        .ovr_clr       (ovr_clr),
        .thresh        (thresh),
        .dout          (dout),
        .dout_err      (dout_err),
        .empty         (empty),
        .full          (full),
        .level         (level),
        .thresh_hit    (thresh_hit),
        .overrun       (overrun),
        .timeout       (timeout)
    );

    always #5 PCLK = ~PCLK;

    int errors = 0;
    int checks = 0;

    // Reference model: queue of {err, byte} entries plus sticky flags and idle s_tick count.
    logic [8:0] q[$];
    logic       m_ovr = 1'b0;
    logic       m_tmo = 1'b0;
    int         m_idle = 0;

    task automatic model_reset();
        q.delete();
        m_ovr  = 1'b0;
        m_tmo  = 1'b0;
        m_idle = 0;
    endtask

    // Drive one clock cycle of inputs, advance the model at the edge, return #1 after it.
    task automatic cycle(input logic d, input logic e, input logic [7:0] data,
                         input logic p, input logic f, input logic oc, input logic st);
        int   sz;
        logic push_any;
        logic pop_ok;
        logic push_ok;
        logic ovr_hit;
        rx_done_tick  = d;
        rx_error_tick = e;
        rx_data       = data;
        pop           = p;
        flush         = f;
        ovr_clr       = oc;
        s_tick        = st;
        @(posedge PCLK);
        sz       = q.size();
        push_any = d | e;
        ovr_hit  = 1'b0;
        if (f) begin
            q.delete();
            m_idle = 0;
            m_tmo  = 1'b0;
        end else begin
            pop_ok  = p && sz > 0;
            push_ok = push_any && (sz < DEPTH || pop_ok);
            ovr_hit = push_any && sz == DEPTH && !pop_ok;
            if (pop_ok || sz == 0)   m_tmo = 1'b0;
            else if (m_idle == TO)   m_tmo = 1'b1;
            if (push_any || pop_ok || sz == 0) m_idle = 0;
            else if (st && m_idle < TO)        m_idle++;
            if (pop_ok)  void'(q.pop_front());
            if (push_ok) q.push_back({e, data});
        end
        if (ovr_hit)  m_ovr = 1'b1;
        else if (oc)  m_ovr = 1'b0;
        #1;
        rx_done_tick  = 1'b0;
        rx_error_tick = 1'b0;
        pop           = 1'b0;
        flush         = 1'b0;
        ovr_clr       = 1'b0;
        s_tick        = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (level !== 5'd0 || full !== 1'b0) begin errors++; $display("FAIL reset_level got=%0d/%b exp=0/0", level, full); end
        checks++; if ({dout_err, dout} !== 9'h000) begin errors++; $display("FAIL reset_dout got=%h exp=000", {dout_err, dout}); end
        checks++; if ({thresh_hit, overrun, timeout} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {thresh_hit, overrun, timeout}); end
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
    endtask

    task automatic test_single();
        cycle(1, 0, 8'hA5, 0, 0, 0, 0);
        checks++; if (empty !== 1'b0 || level !== 5'd1) begin errors++; $display("FAIL single_push empty=%b level=%0d exp=0/1", empty, level); end
        checks++; if (dout !== 8'hA5 || dout_err !== 1'b0) begin errors++; $display("FAIL single_dout got=%h/%b exp=a5/0", dout, dout_err); end
        cycle(0, 0, 8'h00, 1, 0, 0, 0);
        checks++; if (empty !== 1'b1 || dout !== 8'h00) begin errors++; $display("FAIL single_pop empty=%b dout=%h exp=1/00", empty, dout); end
        cycle(0, 0, 8'h00, 1, 0, 0, 0);
        checks++; if (level !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL pop_empty level=%0d exp=0", level); end
    endtask

    task automatic test_full_overrun();
        for (int i = 0; i < 16; i++) cycle(1, 0, 8'(i), 0, 0, 0, 0);
        checks++; if (full !== 1'b1 || level !== 5'd16) begin errors++; $display("FAIL full_level full=%b level=%0d exp=1/16", full, level); end
        cycle(1, 0, 8'hFF, 0, 0, 0, 0);
        checks++; if (overrun !== 1'b1 || level !== 5'd16) begin errors++; $display("FAIL overrun_set ovr=%b level=%0d exp=1/16", overrun, level); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (dout !== 8'(i)) begin errors++; $display("FAIL drain_order idx=%0d got=%h exp=%h", i, dout, 8'(i)); end
            cycle(0, 0, 8'h00, 1, 0, 0, 0);
        end
        checks++; if (empty !== 1'b1 || overrun !== 1'b1) begin errors++; $display("FAIL drained empty=%b ovr=%b exp=1/1", empty, overrun); end
        cycle(0, 0, 8'h00, 0, 0, 1, 0);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr got=%b exp=0", overrun); end
    endtask

    task automatic test_push_pop_full();
        for (int i = 0; i < 16; i++) cycle(1, 0, 8'h80 + 8'(i), 0, 0, 0, 0);
        cycle(1, 0, 8'h55, 1, 0, 0, 0);
        checks++; if (level !== 5'd16 || overrun !== 1'b0) begin errors++; $display("FAIL full_pushpop level=%0d ovr=%b exp=16/0", level, overrun); end
        checks++; if (dout !== 8'h81) begin errors++; $display("FAIL full_pushpop_head got=%h exp=81", dout); end
        for (int i = 0; i < 15; i++) cycle(0, 0, 8'h00, 1, 0, 0, 0);
        checks++; if (dout !== 8'h55 || level !== 5'd1) begin errors++; $display("FAIL full_pushpop_tail got=%h level=%0d exp=55/1", dout, level); end
        cycle(0, 0, 8'h00, 1, 0, 0, 0);
    endtask

    task automatic test_err_thresh();
        thresh = 5'd2;
        cycle(0, 1, 8'h3C, 0, 0, 0, 0);
        checks++; if (thresh_hit !== 1'b0 || dout_err !== 1'b1 || dout !== 8'h3C) begin errors++; $display("FAIL err_first hit=%b err=%b dout=%h exp=0/1/3c", thresh_hit, dout_err, dout); end
        cycle(1, 1, 8'h7E, 0, 0, 0, 0);
        checks++; if (level !== 5'd2 || thresh_hit !== 1'b1) begin errors++; $display("FAIL thresh_hit level=%0d hit=%b exp=2/1", level, thresh_hit); end
        cycle(0, 0, 8'h00, 1, 0, 0, 0);
        checks++; if (dout !== 8'h7E || dout_err !== 1'b1 || thresh_hit !== 1'b0) begin errors++; $display("FAIL err_both dout=%h err=%b hit=%b exp=7e/1/0", dout, dout_err, thresh_hit); end
        thresh = 5'd0;
        #1;
        checks++; if (thresh_hit !== 1'b0) begin errors++; $display("FAIL thresh_zero got=%b exp=0", thresh_hit); end
        cycle(0, 0, 8'h00, 1, 0, 0, 0);
    endtask

    task automatic test_timeout();
        cycle(1, 0, 8'h11, 0, 0, 0, 0);
        for (int i = 0; i < TO; i++) cycle(0, 0, 8'h00, 0, 0, 0, 1);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_early got=%b exp=0", timeout); end
        cycle(0, 0, 8'h00, 0, 0, 0, 0);
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_set got=%b exp=1", timeout); end
        cycle(1, 0, 8'h22, 0, 0, 0, 0);
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_push got=%b exp=1", timeout); end
        cycle(0, 0, 8'h00, 1, 0, 0, 0);
        checks++; if (timeout !== 1'b0 || dout !== 8'h22) begin errors++; $display("FAIL timeout_pop tmo=%b dout=%h exp=0/22", timeout, dout); end
        cycle(0, 0, 8'h00, 1, 0, 0, 0);
    endtask

    task automatic test_flush_wrap();
        for (int i = 0; i < 17; i++) cycle(1, 0, 8'(i), 0, 0, 0, 0);
        for (int i = 0; i < 11; i++) cycle(0, 0, 8'h00, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle(1, 0, 8'h40 + 8'(i), 1, 0, 0, 0);
        checks++; if (level !== 5'd5 || dout !== 8'h4F) begin errors++; $display("FAIL wrap_state level=%0d dout=%h exp=5/4f", level, dout); end
        cycle(1, 0, 8'hEE, 0, 1, 0, 0);
        checks++; if (level !== 5'd0 || empty !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL flush level=%0d empty=%b tmo=%b exp=0/1/0", level, empty, timeout); end
        checks++; if (overrun !== 1'b1 || dout !== 8'h00) begin errors++; $display("FAIL flush_ovr ovr=%b dout=%h exp=1/00", overrun, dout); end
        cycle(0, 0, 8'h00, 0, 0, 1, 0);
    endtask

    task automatic test_random();
        int        n_err;
        logic [8:0] exp_head;
        logic       exp_hit;
        for (int i = 0; i < 600; i++) begin
            n_err = 0;
            thresh = 5'($urandom_range(0, 16));
            cycle($urandom_range(0, 1) == 0, $urandom_range(0, 5) == 0, 8'($urandom),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
            exp_head = (q.size() > 0) ? q[0] : 9'h000;
            exp_hit  = (thresh != 0) && (q.size() >= int'(thresh));
            checks++;
            if ({dout_err, dout} !== exp_head || level !== 5'(q.size()) || empty !== (q.size() == 0) ||
                full !== (q.size() == DEPTH) || thresh_hit !== exp_hit || overrun !== m_ovr || timeout !== m_tmo) begin
                errors++;
                $display("FAIL random cyc=%0d head=%h/%h level=%0d/%0d hit=%b/%b ovr=%b/%b tmo=%b/%b",
                         i, {dout_err, dout}, exp_head, level, q.size(), thresh_hit, exp_hit,
                         overrun, m_ovr, timeout, m_tmo);
            end
        end
        thresh = 5'd0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 17; i++) cycle(1, 0, 8'hC0 + 8'(i), 0, 0, 0, 0);
        #2;
        PRESETn = 1'b0;
        #1;
        checks++; if (empty !== 1'b1 || level !== 5'd0 || full !== 1'b0) begin errors++; $display("FAIL async_level empty=%b level=%0d full=%b exp=1/0/0", empty, level, full); end
        checks++; if ({dout_err, dout} !== 9'h000 || overrun !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL async_flags dout=%h ovr=%b tmo=%b exp=000/0/0", {dout_err, dout}, overrun, timeout); end
        model_reset();
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        cycle(1, 0, 8'h5A, 0, 0, 0, 0);
        checks++; if (level !== 5'd1 || dout !== 8'h5A) begin errors++; $display("FAIL after_reset level=%0d dout=%h exp=1/5a", level, dout); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_full_overrun();
        test_push_pop_full();
        test_err_thresh();
        test_timeout();
        test_flush_wrap();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
